// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32-entry register file: round-robin writeback arbiter plus busy scoreboard.
// Optional REGFILE_WB_ARB_STATS_EN adds saturating wb_count / conflict_count outputs.
module regfile_wb_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NREQ      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd,
  input  logic [4:0]                issue_rs1,
  input  logic [4:0]                issue_rs2,
  output logic                      issue_ready,
  output logic                      hazard,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*5-1:0]         req_reg,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rf_write,
  output logic [4:0]                rf_writeReg,
  output logic [DATAWIDTH-1:0]      rf_writeData,
  output logic [31:0]               busy_mask
`ifdef REGFILE_WB_ARB_STATS_EN
  ,
  output logic [15:0]               wb_count,
  output logic [15:0]               conflict_count
`endif
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [4:0]           reg_arr  [NREQ];
  logic [DATAWIDTH-1:0] data_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign reg_arr[gi]  = req_reg[5*gi +: 5];
      assign data_arr[gi] = req_data[DATAWIDTH*gi +: DATAWIDTH];
    end
  endgenerate

  logic [PW-1:0]        ptr_reg;
  logic                 write_reg;
  logic [4:0]           addr_reg;
  logic [DATAWIDTH-1:0] data_reg;
  logic [31:0]          busy_reg, busy_next;

  logic [NREQ-1:0]      grant_vec;
  logic                 grant_any;
  logic [PW-1:0]        grant_idx;
  logic [PW-1:0]        cand;
  logic [PW:0]          sum;
  logic [4:0]           sel_reg;
  logic [DATAWIDTH-1:0] sel_data;

  // Round-robin search from ptr+1, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    sum       = '0;
    sel_reg   = '0;
    sel_data  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, ptr_reg} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      cand = sum[PW-1:0];
      if (!grant_any && req_valid[cand]) begin
        grant_any       = 1'b1;
        grant_idx       = cand;
        grant_vec[cand] = 1'b1;
        sel_reg         = reg_arr[cand];
        sel_data        = data_arr[cand];
      end
    end
  end

  assign req_ready = grant_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= PW'(NREQ - 1);
      write_reg <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      write_reg <= grant_any && (sel_reg != 5'd0);
      if (grant_any) begin
        ptr_reg  <= grant_idx;
        addr_reg <= sel_reg;
        data_reg <= sel_data;
      end
    end
  end

  assign rf_write     = write_reg;
  assign rf_writeReg  = addr_reg;
  assign rf_writeData = data_reg;

  assign hazard      = busy_reg[issue_rs1] | busy_reg[issue_rs2];
  assign issue_ready = !(busy_reg[issue_rd] && (issue_rd != 5'd0)) && !hazard;

  // Clear on the register-file commit edge; a same-edge issue to that register re-sets it.
  always_comb begin
    busy_next = busy_reg;
    if (write_reg)
      busy_next[addr_reg] = 1'b0;
    if (issue_valid && issue_ready && (issue_rd != 5'd0))
      busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  assign busy_mask = busy_reg;

`ifdef REGFILE_WB_ARB_STATS_EN
  logic [15:0] wb_count_reg;
  logic [15:0] conflict_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_count_reg       <= '0;
      conflict_count_reg <= '0;
    end else begin
      if (write_reg && (wb_count_reg != 16'hFFFF))
        wb_count_reg <= wb_count_reg + 16'd1;
      if (($countones(req_valid) >= 2) && (conflict_count_reg != 16'hFFFF))
        conflict_count_reg <= conflict_count_reg + 16'd1;
    end
  end

  assign wb_count       = wb_count_reg;
  assign conflict_count = conflict_count_reg;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected register-file writes, a monitor checks them.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic [4:0]      issue_rd, issue_rs1, issue_rs2;
  logic            issue_ready, hazard;
  logic [NR-1:0]   req_valid;
  logic [NR*5-1:0] req_reg;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rf_write;
  logic [4:0]      rf_writeReg;
  logic [DW-1:0]   rf_writeData;
  logic [31:0]     busy_mask;
`ifdef REGFILE_WB_ARB_STATS_EN
  logic [15:0]     wb_count, conflict_count;
`endif

  regfile_wb_arbiter #(.DATAWIDTH(DW), .NREQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_ready(issue_ready), .hazard(hazard),
    .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data), .req_ready(req_ready),
    .rf_write(rf_write), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
    .busy_mask(busy_mask)
`ifdef REGFILE_WB_ARB_STATS_EN
    , .wb_count(wb_count), .conflict_count(conflict_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [36:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  // Monitor: every committed write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_write === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got reg %0d data %0h expected no write", rf_writeReg, rf_writeData);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_writeReg, rf_writeData} !== e) begin
          n_fail++;
          $display("FAIL wb_data: got reg %0d data %0h expected reg %0d data %0h",
                   rf_writeReg, rf_writeData, e[36:32], e[31:0]);
        end else
          $display("ok   wb: reg %0d data %0h", rf_writeReg, rf_writeData);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
    req_valid[i]       = v;
    req_reg[5*i +: 5]  = r;
    req_data[DW*i +: DW] = d;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (cycles) step();
    rst_n = 1'b1;
    #1;
  endtask

  logic [31:0] d0, d1;

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    req_valid = '0; req_reg = '0; req_data = '0;

    // Reset then idle
    #2;
    check("reset_rf_write", {63'b0, rf_write}, 64'd0);
    check("reset_busy", {32'b0, busy_mask}, 64'd0);
    do_reset(3);
    step();
    check("idle_rf_write", {63'b0, rf_write}, 64'd0);
    check("idle_req_ready", {62'b0, req_ready}, 64'd0);
    check("idle_busy", {32'b0, busy_mask}, 64'd0);

    // Single writeback to r5
    issue_valid = 1'b1; issue_rd = 5'd5; #1;
    check("issue5_ready", {63'b0, issue_ready}, 64'd1);
    step();
    issue_valid = 1'b0;
    check("busy5_set", {32'b0, busy_mask}, 64'h20);
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF); #1;
    check("grant_r0", {62'b0, req_ready}, 64'b01);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check("wb5_write", {63'b0, rf_write}, 64'd1);
    check("busy5_during_write", {32'b0, busy_mask}, 64'h20);
    step();
    check("busy5_cleared", {32'b0, busy_mask}, 64'd0);
    check("wb5_write_low", {63'b0, rf_write}, 64'd0);

    // Round robin after reset: grants 0,1,0,1
    do_reset(1);
    d0 = 32'h100; d1 = 32'h200;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 5'd1, d0);
      set_req(1, 1'b1, 5'd2, d1);
      #1;
      check($sformatf("rr_grant_%0d", k), {62'b0, req_ready}, (k % 2 == 0) ? 64'b01 : 64'b10);
      if (k > 0) check($sformatf("rr_write_%0d", k), {63'b0, rf_write}, 64'd1);
      if (k % 2 == 0) exp_q.push_back({5'd1, d0});
      else            exp_q.push_back({5'd2, d1});
      step();
      if (k % 2 == 0) d0 = d0 + 1; else d1 = d1 + 1;
    end
    req_valid = '0;
    check("rr_last_write", {63'b0, rf_write}, 64'd1);
    step();
    check("rr_busy_untouched", {32'b0, busy_mask}, 64'd0);

    // Hazard stall on r7
    issue_valid = 1'b1; issue_rd = 5'd7; issue_rs1 = 5'd0; issue_rs2 = 5'd0; #1;
    check("issue7_ready", {63'b0, issue_ready}, 64'd1);
    step();
    issue_rd = 5'd8; issue_rs1 = 5'd7; #1;
    check("raw_hazard", {63'b0, hazard}, 64'd1);
    check("raw_not_ready", {63'b0, issue_ready}, 64'd0);
    issue_rd = 5'd7; issue_rs1 = 5'd0; #1;
    check("waw_not_ready", {63'b0, issue_ready}, 64'd0);
    issue_rd = 5'd8; issue_rs1 = 5'd0; issue_rs2 = 5'd7;
    set_req(1, 1'b1, 5'd7, 32'h77); #1;
    check("grant_r1_hz", {62'b0, req_ready}, 64'b10);
    exp_q.push_back({5'd7, 32'h77});
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    check("hazard_during_write", {63'b0, hazard}, 64'd1);
    check("busy7_during_write", {32'b0, busy_mask}, 64'h80);
    step();
    issue_valid = 1'b0; #1;
    check("hazard_cleared", {63'b0, hazard}, 64'd0);
    check("ready_after_commit", {63'b0, issue_ready}, 64'd1);

    // x0 write: accepted, no register-file write
    set_req(1, 1'b1, 5'd0, 32'h1234); #1;
    check("x0_grant", {62'b0, req_ready}, 64'b10);
    step();
    set_req(1, 1'b0, 5'd0, 32'h0);
    check("x0_no_write", {63'b0, rf_write}, 64'd0);
    check("x0_busy0", {63'b0, busy_mask[0]}, 64'd0);
    step();

    // Reset in the rf_write cycle
    issue_valid = 1'b1; issue_rd = 5'd9; issue_rs2 = 5'd0; step();
    issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd9, 32'h99);
    exp_q.push_back({5'd9, 32'h99});
    step();
    set_req(0, 1'b0, 5'd0, 32'h0);
    check("mid_write_high", {63'b0, rf_write}, 64'd1);
    check("mid_busy9", {32'b0, busy_mask}, 64'h200);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_write", {63'b0, rf_write}, 64'd0);
    check("mid_rst_busy", {32'b0, busy_mask}, 64'd0);
`ifdef REGFILE_WB_ARB_STATS_EN
    check("mid_rst_wb_count", {48'b0, wb_count}, 64'd0);
    check("mid_rst_conflict", {48'b0, conflict_count}, 64'd0);
`endif
    step();
    rst_n = 1'b1;
    step(); step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
